cic_rate_ctrl: RTL and testbench
================================

CIC_RATE_CTRL -- requirements
Module: cic_rate_ctrl

Interface
REQ-001 SHALL have parameter RATE_DW, default 32: width of the rate word.
REQ-002 SHALL have parameter CIC_N, default 7: number of stages of the controlled decimator.
REQ-003 SHALL have parameter RATE_MIN, default 2: smallest legal decimation ratio.
REQ-004 SHALL have parameter RATE_MAX, default 10: largest legal ratio; equals the decimator's CIC_R.
REQ-005 SHALL have parameter RATE_DEF, default 10: ratio applied after reset.
REQ-006 SHALL have parameter SETTLE_OUT, default CIC_N: number of decimator outputs discarded after each rate change.
REQ-007 SHALL have port clk, input, 1 bit: clock.
REQ-008 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port s_axis_cfg_tdata, input, RATE_DW bits: requested ratio, unsigned.
REQ-010 SHALL have port s_axis_cfg_tvalid, input, 1 bit: request valid.
REQ-011 SHALL have port s_axis_cfg_tready, output, 1 bit: controller can accept a request.
REQ-012 SHALL have port s_in_tvalid, input, 1 bit: upstream sample strobe.
REQ-013 SHALL have port m_cic_in_tvalid, output, 1 bit: gated sample strobe to the decimator.
REQ-014 SHALL have port m_rate_tdata, output, RATE_DW bits: ratio driven to the decimator.
REQ-015 SHALL have port m_rate_tvalid, output, 1 bit: one-cycle ratio load strobe.
REQ-016 SHALL have port s_cic_out_tvalid, input, 1 bit: decimator output strobe.
REQ-017 SHALL have port m_out_tvalid, output, 1 bit: gated output strobe downstream.
REQ-018 SHALL have port rate_cur, output, RATE_DW bits: ratio currently in effect.
REQ-019 SHALL have port busy, output, 1 bit: high whenever state is not RUN.
REQ-020 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an illegal request is rejected.
REQ-021 SHALL have port drop_cnt, output, 16 bits: count of input strobes blocked, saturating.

Function
REQ-022 SHALL implement the states INIT, APPLY, SETTLE and RUN; data buses are not handled by this block, only strobes.
REQ-023 INIT SHALL last exactly one cycle after reset release, then go to APPLY with the pending ratio set to RATE_DEF.
REQ-024 s_axis_cfg_tready SHALL be 1 only in RUN; a handshake is tvalid & tready on a rising clk edge.
REQ-025 A handshake with RATE_MIN <= tdata <= RATE_MAX SHALL latch tdata as the pending ratio and move the state to APPLY on the next cycle.
REQ-026 A handshake with an out-of-range tdata SHALL be consumed, raise cfg_err for one cycle starting the next cycle, and leave state and rate_cur unchanged.
REQ-027 APPLY SHALL last exactly one cycle, during which:
- m_rate_tvalid = 1;
- m_rate_tdata = pending ratio;
- rate_cur is updated at the end of the cycle.
REQ-028 In APPLY, m_cic_in_tvalid SHALL be 0, and each s_in_tvalid in that cycle increments drop_cnt.
REQ-029 APPLY SHALL go to SETTLE, or directly to RUN if SETTLE_OUT = 0.
REQ-030 In SETTLE, m_cic_in_tvalid SHALL equal s_in_tvalid and m_out_tvalid SHALL be 0.
REQ-031 A counter in SETTLE SHALL count s_cic_out_tvalid pulses; on the SETTLE_OUT-th pulse the state goes to RUN next cycle, and that pulse is also suppressed.
REQ-032 In RUN, m_cic_in_tvalid SHALL equal s_in_tvalid and m_out_tvalid SHALL equal s_cic_out_tvalid, both combinational with zero latency.
REQ-033 A cfg handshake in RUN SHALL NOT suppress same-cycle strobes; gating starts in the following APPLY cycle.
REQ-034 m_rate_tdata SHALL hold rate_cur outside APPLY; m_rate_tvalid = 0 outside APPLY.
REQ-035 drop_cnt SHALL saturate at 0xFFFF and SHALL never wrap.
REQ-036 Illegal parameters (RATE_MIN < 1, RATE_MIN > RATE_MAX, RATE_DEF outside the legal range) SHALL cause an elaboration-time error.

Reset
REQ-037 On reset_n = 0, the block SHALL immediately:
- enter INIT;
- set rate_cur = RATE_DEF, m_rate_tdata = RATE_DEF;
- set m_rate_tvalid = 0, cfg_err = 0, drop_cnt = 0;
- clear the settle counter.
REQ-038 During reset, m_cic_in_tvalid and m_out_tvalid SHALL be 0 regardless of their inputs; busy = 1; s_axis_cfg_tready = 0.
REQ-039 Reset asserted mid-APPLY or mid-SETTLE SHALL abandon the change; after release the block re-applies RATE_DEF via INIT.

Verification
REQ-040 Reset release with CIC_N=7 and an input strobe every cycle:
- m_rate_tvalid pulses once with tdata = 10 on cycle 2;
- drop_cnt = 1;
- the first 7 s_cic_out_tvalid pulses are suppressed, the 8th passes;
- busy falls the cycle after the 7th pulse.
REQ-041 In RUN, cfg tdata = 4:
- tready drops the next cycle;
- m_rate_tvalid pulses with tdata = 4;
- rate_cur = 4 afterwards;
- 7 outputs are suppressed, then pass-through resumes.
REQ-042 In RUN, cfg tdata = 1 and then tdata = 11:
- two cfg_err pulses;
- no m_rate_tvalid;
- rate_cur unchanged;
- tready stays 1.
REQ-043 cfg tvalid held high during SETTLE is not accepted until RUN; it is then accepted and a second APPLY follows.
REQ-044 Assert reset_n low during SETTLE:
- outputs return to reset values asynchronously;
- after release the RATE_DEF re-apply sequence of REQ-040 repeats.
REQ-045 Force 70000 strobes into APPLY windows; drop_cnt SHALL read 0xFFFF and SHALL NOT wrap.

Source files
------------

// File: rtl/cic_rate_ctrl.sv
// Rate controller for a CIC decimator: loads a new decimation ratio, gates the
// sample/output strobes around the change and discards the settling outputs.
module cic_rate_ctrl #(
  parameter int RATE_DW    = 32,
  parameter int CIC_N      = 7,
  parameter int RATE_MIN   = 2,
  parameter int RATE_MAX   = 10,
  parameter int RATE_DEF   = 10,
  parameter int SETTLE_OUT = CIC_N
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
  input  logic               s_axis_cfg_tvalid,
  output logic               s_axis_cfg_tready,
  input  logic               s_in_tvalid,
  output logic               m_cic_in_tvalid,
  output logic [RATE_DW-1:0] m_rate_tdata,
  output logic               m_rate_tvalid,
  input  logic               s_cic_out_tvalid,
  output logic               m_out_tvalid,
  output logic [RATE_DW-1:0] rate_cur,
  output logic               busy,
  output logic               cfg_err,
  output logic [15:0]        drop_cnt
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  localparam int CNT_W = (SETTLE_OUT > 1) ? $clog2(SETTLE_OUT) : 1;
  localparam logic [CNT_W-1:0]   SETTLE_LAST = (SETTLE_OUT > 0) ? CNT_W'(SETTLE_OUT - 1) : {CNT_W{1'b0}};
  localparam logic [RATE_DW-1:0] RATE_MIN_W  = RATE_DW'(RATE_MIN);
  localparam logic [RATE_DW-1:0] RATE_MAX_W  = RATE_DW'(RATE_MAX);
  localparam logic [RATE_DW-1:0] RATE_DEF_W  = RATE_DW'(RATE_DEF);

  if (RATE_MIN < 1 || RATE_MIN > RATE_MAX || RATE_DEF < RATE_MIN || RATE_DEF > RATE_MAX) begin : g_bad_params
    $error("cic_rate_ctrl: illegal RATE_MIN/RATE_MAX/RATE_DEF combination");
  end

  logic [1:0]         state_r, state_nxt_s;
  logic [RATE_DW-1:0] pend_r, pend_nxt_s;
  logic [RATE_DW-1:0] rate_cur_r, rate_cur_nxt_s;
  logic [CNT_W-1:0]   settle_cnt_r, settle_cnt_nxt_s;
  logic               cfg_err_r, cfg_err_nxt_s;
  logic [15:0]        drop_cnt_r, drop_cnt_nxt_s;
  logic               cfg_hs_s;
  logic               cfg_legal_s;

  assign cfg_hs_s    = s_axis_cfg_tvalid & (state_r == ST_RUN);
  assign cfg_legal_s = (s_axis_cfg_tdata >= RATE_MIN_W) && (s_axis_cfg_tdata <= RATE_MAX_W);

  // Next-state and datapath update for the rate-change sequence
  always_comb begin
    state_nxt_s      = state_r;
    pend_nxt_s       = pend_r;
    rate_cur_nxt_s   = rate_cur_r;
    settle_cnt_nxt_s = settle_cnt_r;
    cfg_err_nxt_s    = 1'b0;
    drop_cnt_nxt_s   = drop_cnt_r;
    case (state_r)
      ST_INIT: begin
        state_nxt_s = ST_APPLY;
        pend_nxt_s  = RATE_DEF_W;
      end
      ST_APPLY: begin
        rate_cur_nxt_s   = pend_r;
        settle_cnt_nxt_s = {CNT_W{1'b0}};
        if (SETTLE_OUT == 0) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
        // Input strobes are blocked while the decimator reloads its ratio
        if (s_in_tvalid && (drop_cnt_r != 16'hFFFF)) begin
          drop_cnt_nxt_s = drop_cnt_r + 16'd1;
        end else begin
          drop_cnt_nxt_s = drop_cnt_r;
        end
      end
      ST_SETTLE: begin
        if (s_cic_out_tvalid) begin
          if (settle_cnt_r == SETTLE_LAST) begin
            state_nxt_s = ST_RUN;
          end else begin
            settle_cnt_nxt_s = settle_cnt_r + CNT_W'(1);
          end
        end else begin
          settle_cnt_nxt_s = settle_cnt_r;
        end
      end
      ST_RUN: begin
        if (cfg_hs_s) begin
          if (cfg_legal_s) begin
            pend_nxt_s  = s_axis_cfg_tdata;
            state_nxt_s = ST_APPLY;
          end else begin
            cfg_err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_INIT;
      pend_r       <= RATE_DEF_W;
      rate_cur_r   <= RATE_DEF_W;
      settle_cnt_r <= {CNT_W{1'b0}};
      cfg_err_r    <= 1'b0;
      drop_cnt_r   <= 16'h0000;
    end else begin
      state_r      <= state_nxt_s;
      pend_r       <= pend_nxt_s;
      rate_cur_r   <= rate_cur_nxt_s;
      settle_cnt_r <= settle_cnt_nxt_s;
      cfg_err_r    <= cfg_err_nxt_s;
      drop_cnt_r   <= drop_cnt_nxt_s;
    end
  end

  // Strobe gating is combinational so pass-through in RUN has zero latency
  assign s_axis_cfg_tready = (state_r == ST_RUN);
  assign busy              = (state_r != ST_RUN);
  assign m_cic_in_tvalid   = s_in_tvalid & ((state_r == ST_SETTLE) || (state_r == ST_RUN));
  assign m_out_tvalid      = s_cic_out_tvalid & (state_r == ST_RUN);
  assign m_rate_tvalid     = (state_r == ST_APPLY);
  assign m_rate_tdata      = (state_r == ST_APPLY) ? pend_r : rate_cur_r;
  assign rate_cur          = rate_cur_r;
  assign cfg_err           = cfg_err_r;
  assign drop_cnt          = drop_cnt_r;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Scoreboard bench for cic_rate_ctrl: a phase-level reference model predicts
// every strobe, rate load and error pulse; a negedge monitor compares.
module tb_cic_rate_ctrl;

  localparam int DW       = 32;
  localparam int RMIN     = 2;
  localparam int RMAX     = 10;
  localparam int RDEF     = 10;
  localparam int SETTLE_N = 7;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] s_axis_cfg_tdata;
  logic          s_axis_cfg_tvalid;
  logic          s_axis_cfg_tready;
  logic          s_in_tvalid;
  logic          m_cic_in_tvalid;
  logic [DW-1:0] m_rate_tdata;
  logic          m_rate_tvalid;
  logic          s_cic_out_tvalid;
  logic          m_out_tvalid;
  logic [DW-1:0] rate_cur;
  logic          busy;
  logic          cfg_err;
  logic [15:0]   drop_cnt;

  cic_rate_ctrl #(
    .RATE_DW(DW), .CIC_N(7), .RATE_MIN(RMIN), .RATE_MAX(RMAX), .RATE_DEF(RDEF), .SETTLE_OUT(SETTLE_N)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_cfg_tdata(s_axis_cfg_tdata), .s_axis_cfg_tvalid(s_axis_cfg_tvalid),
    .s_axis_cfg_tready(s_axis_cfg_tready), .s_in_tvalid(s_in_tvalid),
    .m_cic_in_tvalid(m_cic_in_tvalid), .m_rate_tdata(m_rate_tdata),
    .m_rate_tvalid(m_rate_tvalid), .s_cic_out_tvalid(s_cic_out_tvalid),
    .m_out_tvalid(m_out_tvalid), .rate_cur(rate_cur), .busy(busy),
    .cfg_err(cfg_err), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase described by "first cycle after reset", "loading",
  // and "outputs still to discard"; everything else is normal running.
  bit          m_init;
  bit          m_apply;
  int          m_discard;
  logic [31:0] m_rate;
  logic [31:0] m_pend;
  int          m_drop;
  bit          m_err_now;
  logic [31:0] rate_q[$];
  logic [31:0] err_q[$];

  bit          chk_en;
  bit          exp_cic_in, exp_out, exp_busy, exp_ready, exp_rate_v, exp_err;
  logic [31:0] exp_rate_d, exp_rate_cur;
  int          exp_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit model_run();
    return !m_init && !m_apply && (m_discard == 0);
  endfunction

  task automatic model_reset();
    m_init = 1'b1; m_apply = 1'b0; m_discard = 0;
    m_rate = 32'(RDEF); m_pend = 32'(RDEF); m_drop = 0; m_err_now = 1'b0;
    rate_q.delete(); err_q.delete();
  endtask

  // One clock cycle: drive inputs, publish expectations, advance the model.
  task automatic step(input bit in_v, input bit out_v, input bit cfg_v, input logic [31:0] cfg_d, output bit acc);
    bit run;
    bit err_nx;
    s_in_tvalid = in_v; s_cic_out_tvalid = out_v;
    s_axis_cfg_tvalid = cfg_v; s_axis_cfg_tdata = cfg_d;
    run = model_run();
    exp_ready = run; exp_busy = !run;
    exp_cic_in = in_v && !m_init && !m_apply;
    exp_out = out_v && run;
    exp_rate_v = m_apply;
    exp_rate_d = m_apply ? m_pend : m_rate;
    exp_rate_cur = m_rate; exp_drop = m_drop; exp_err = m_err_now;
    if (m_apply) rate_q.push_back(m_pend);
    acc = 1'b0; err_nx = 1'b0;
    if (m_init) begin
      m_init = 1'b0; m_apply = 1'b1; m_pend = 32'(RDEF);
    end else if (m_apply) begin
      m_rate = m_pend; m_apply = 1'b0; m_discard = SETTLE_N;
      if (in_v && m_drop < 65535) m_drop++;
    end else if (m_discard > 0) begin
      if (out_v) m_discard--;
    end else if (cfg_v) begin
      acc = 1'b1;
      if (cfg_d >= 32'(RMIN) && cfg_d <= 32'(RMAX)) begin
        m_apply = 1'b1; m_pend = cfg_d;
      end else begin
        err_nx = 1'b1; err_q.push_back(cfg_d);
      end
    end
    m_err_now = err_nx;
    @(posedge clk); #1;
  endtask

  task automatic to_run(input bit in_v, input bit out_every, input int max_cyc);
    bit acc;
    for (int i = 0; i < max_cyc && !model_run(); i++)
      step(in_v, out_every ? 1'b1 : 1'($urandom % 2), 1'b0, 32'd0, acc);
    chk("reach_run_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_tready"}, 32'(s_axis_cfg_tready), 32'd0);
    chk({tag, "_cic_in"}, 32'(m_cic_in_tvalid), 32'd0);
    chk({tag, "_out"}, 32'(m_out_tvalid), 32'd0);
    chk({tag, "_rate_v"}, 32'(m_rate_tvalid), 32'd0);
    chk({tag, "_rate_d"}, m_rate_tdata, 32'(RDEF));
    chk({tag, "_rate_cur"}, rate_cur, 32'(RDEF));
    chk({tag, "_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  // Asynchronous reset mid-cycle with strobes high, then release after an edge.
  task automatic do_reset(input string tag);
    chk_en = 1'b0;
    #2;
    s_in_tvalid = 1'b1; s_cic_out_tvalid = 1'b1; s_axis_cfg_tvalid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_values(tag);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
  endtask

  // Monitor: compare strobes every cycle and pop scoreboard entries on events.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cic_in", 32'(m_cic_in_tvalid), 32'(exp_cic_in));
      chk("out", 32'(m_out_tvalid), 32'(exp_out));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("tready", 32'(s_axis_cfg_tready), 32'(exp_ready));
      chk("rate_v", 32'(m_rate_tvalid), 32'(exp_rate_v));
      chk("rate_d", m_rate_tdata, exp_rate_d);
      chk("rate_cur", rate_cur, exp_rate_cur);
      chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
      chk("cfg_err", 32'(cfg_err), 32'(exp_err));
      if (m_rate_tvalid) begin
        chk("rate_load_expected", 32'(rate_q.size() != 0), 32'd1);
        if (rate_q.size() != 0) chk("rate_load_value", m_rate_tdata, rate_q.pop_front());
      end
      if (cfg_err) begin
        chk("err_expected", 32'(err_q.size() != 0), 32'd1);
        if (err_q.size() != 0) void'(err_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    chk_en = 1'b0;
    reset_n = 1'b1;
    s_in_tvalid = 1'b0; s_cic_out_tvalid = 1'b0;
    s_axis_cfg_tvalid = 1'b0; s_axis_cfg_tdata = '0;
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_values("por");
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // Power-up default load with strobes every cycle
    to_run(1'b1, 1'b1, 40);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0, acc);

    // Legal change to 4
    step(1'b1, 1'b1, 1'b1, 32'd4, acc);
    chk("accept_4", 32'(acc), 32'd1);
    to_run(1'b1, 1'b1, 40);
    chk("rate_cur_4", rate_cur, 32'd4);

    // Two illegal requests, back to back
    step(1'b1, 1'b1, 1'b1, 32'd1, acc);
    step(1'b1, 1'b0, 1'b1, 32'd11, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0, acc);
    chk("rate_cur_after_bad", rate_cur, 32'd4);

    // Request held during SETTLE is only taken in RUN
    step(1'b1, 1'b0, 1'b1, 32'd3, acc);
    acc = 1'b0;
    for (int i = 0; i < 60 && !acc; i++) step(1'b1, 1'(i % 2), 1'b1, 32'd5, acc);
    chk("held_accept", 32'(acc), 32'd1);
    to_run(1'b1, 1'b0, 80);
    chk("rate_cur_5", rate_cur, 32'd5);

    // Reset in the middle of SETTLE, then the default sequence again
    step(1'b1, 1'b1, 1'b1, 32'd6, acc);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0, acc);
    do_reset("mid_settle");
    to_run(1'b1, 1'b1, 40);

    // Saturation of the drop counter: preload near full, then many loads
    force dut.drop_cnt_r = 16'hFFF0;
    #1;
    release dut.drop_cnt_r;
    m_drop = 32'hFFF0;
    step(1'b0, 1'b0, 1'b0, 32'd0, acc);
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 1'b0, 1'b1, 32'($urandom_range(RMIN, RMAX)), acc);
      to_run(1'b1, 1'b1, 40);
    end
    chk("drop_saturated", 32'(drop_cnt), 32'hFFFF);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      logic [31:0] d;
      d = ($urandom % 16 == 0) ? $urandom : 32'($urandom_range(0, 12));
      step(1'($urandom % 2), 1'($urandom % 3 == 0), 1'($urandom % 8 == 0), d, acc);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0, acc);

    chk("rate_q_empty", 32'(rate_q.size()), 32'd0);
    chk("err_q_empty", 32'(err_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
